// File: rtl/music_player_poly.sv
// Multi-voice music player top: transport FSM, frame sync, beat divider and saturating voice mixer.
// Optional MUSIC_PLAYER_AUTOPLAY_EN: song_done while playing resumes playback on the next song.
module music_player_poly #(
    parameter int NUM_SONGS = 4,
    parameter int SONG_BITS = 2,
    parameter int VOICES    = 2,
    parameter int SAMPLE_W  = 16,
    parameter int BEAT_DIV  = 1000,
    parameter int BEAT_BITS = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play_pause,
    input  logic                         next,
    input  logic                         prev,
    input  logic                         NewFrame,
    input  logic                         song_done,
    input  logic [VOICES*SAMPLE_W-1:0]   voice_sample,
    output logic                         ready,
    output logic                         beat,
    output logic                         play,
    output logic [SONG_BITS-1:0]         song,
    output logic                         reset_play,
    output logic [SAMPLE_W-1:0]          sample,
    output logic                         sample_valid
);
    typedef enum logic [1:0] {RESET_PLAY, PAUSED, PLAYING, ADVANCE} state_t;

`ifdef MUSIC_PLAYER_AUTOPLAY_EN
    localparam state_t DONE_TARGET = PLAYING;
`else
    localparam state_t DONE_TARGET = PAUSED;
`endif

    localparam int SUM_W = SAMPLE_W + 3;
    localparam logic signed [SUM_W-1:0] SAT_MAX = {4'b0000, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {4'b1111, {(SAMPLE_W-1){1'b0}}};

    state_t                 state_q, state_d, target_q, target_d;
    logic                   fwd_q, fwd_d;
    logic [SONG_BITS-1:0]   song_q, song_d;
    logic                   reset_play_q;
    logic                   nf_s1_q, nf_s2_q, nf_s3_q, ready_q;
    logic [BEAT_BITS-1:0]   beat_cnt_q;
    logic                   beat_q;
    logic [SAMPLE_W-1:0]    sample_q;
    logic                   sample_valid_q;
    logic signed [SUM_W-1:0] mix_sum;
    logic [SAMPLE_W-1:0]    mix_sat;
    logic                   step;

    // next and prev together cancel each other; play_pause still gets through.
    assign step = next ^ prev;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        fwd_d    = fwd_q;
        song_d   = song_q;
        case (state_q)
            RESET_PLAY: state_d = target_q;
            PAUSED: begin
                if (step) begin
                    state_d  = ADVANCE;
                    fwd_d    = next;
                    target_d = PAUSED;
                end else if (play_pause) begin
                    state_d = PLAYING;
                end
            end
            PLAYING: begin
                if (step) begin
                    state_d  = ADVANCE;
                    fwd_d    = next;
                    target_d = PLAYING;
                end else if (song_done) begin
                    state_d  = ADVANCE;
                    fwd_d    = 1'b1;
                    target_d = DONE_TARGET;
                end else if (play_pause) begin
                    state_d = PAUSED;
                end
            end
            ADVANCE: begin
                if (fwd_q)
                    song_d = (song_q == SONG_BITS'(NUM_SONGS-1)) ? '0 : song_q + 1'b1;
                else
                    song_d = (song_q == '0) ? SONG_BITS'(NUM_SONGS-1) : song_q - 1'b1;
                state_d = RESET_PLAY;
            end
            default: state_d = RESET_PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RESET_PLAY;
            target_q     <= PAUSED;
            fwd_q        <= 1'b1;
            song_q       <= '0;
            reset_play_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            fwd_q        <= fwd_d;
            song_q       <= song_d;
            reset_play_q <= (state_q == RESET_PLAY);
        end
    end

    // Two-flop synchroniser plus a third flop for rising-edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            nf_s1_q <= 1'b0;
            nf_s2_q <= 1'b0;
            nf_s3_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            nf_s1_q <= NewFrame;
            nf_s2_q <= nf_s1_q;
            nf_s3_q <= nf_s2_q;
            ready_q <= nf_s2_q & ~nf_s3_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || reset_play_q) begin
            beat_cnt_q <= '0;
            beat_q     <= 1'b0;
        end else begin
            beat_q <= 1'b0;
            if (ready_q) begin
                if (beat_cnt_q == BEAT_BITS'(BEAT_DIV-1)) begin
                    beat_cnt_q <= '0;
                    beat_q     <= 1'b1;
                end else begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < VOICES; v++)
            mix_sum = mix_sum + SUM_W'($signed(voice_sample[v*SAMPLE_W +: SAMPLE_W]));
        if (mix_sum > SAT_MAX)
            mix_sat = SAT_MAX[SAMPLE_W-1:0];
        else if (mix_sum < SAT_MIN)
            mix_sat = SAT_MIN[SAMPLE_W-1:0];
        else
            mix_sat = mix_sum[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= ready_q;
            if (ready_q)
                sample_q <= play ? mix_sat : '0;
        end
    end

    assign ready        = ready_q;
    assign beat         = beat_q;
    assign play         = (state_q == PLAYING);
    assign song         = song_q;
    assign reset_play   = reset_play_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
endmodule

// File: tb/tb_music_player_poly.sv
// Directed bench for music_player_poly: transport, frame sync, beat divider, mixer saturation.
module tb_music_player_poly;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play_pause = 1'b0, next = 1'b0, prev = 1'b0;
    logic        NewFrame = 1'b0, song_done = 1'b0;
    logic [31:0] voice_sample = '0;
    logic        ready, beat, play, reset_play, sample_valid;
    logic [1:0]  song;
    logic [15:0] sample;

    int n_checks = 0;
    int n_fail   = 0;

    music_player_poly #(
        .NUM_SONGS(4), .SONG_BITS(2), .VOICES(2), .SAMPLE_W(16),
        .BEAT_DIV(64), .BEAT_BITS(10)
    ) dut (
        .clk(clk), .reset(reset), .play_pause(play_pause), .next(next), .prev(prev),
        .NewFrame(NewFrame), .song_done(song_done), .voice_sample(voice_sample),
        .ready(ready), .beat(beat), .play(play), .song(song), .reset_play(reset_play),
        .sample(sample), .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One NewFrame rising edge; returns ready seen 3 clk later and the outputs one clk after that.
    task automatic frame(output logic r, output logic b, output logic sv, output logic [15:0] s);
        NewFrame = 1'b1;
        tick(); tick(); tick();
        r = ready;
        tick();
        b = beat; sv = sample_valid; s = sample;
        NewFrame = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic n, input logic p, input logic pp, input logic sd, output int rp);
        next = n; prev = p; play_pause = pp; song_done = sd;
        tick();
        next = 1'b0; prev = 1'b0; play_pause = 1'b0; song_done = 1'b0;
        rp = 0;
        repeat (4) begin
            tick();
            if (reset_play) rp++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
    endtask

    initial begin
        logic r, b, sv;
        logic [15:0] s;
        int rp, nready, nbeats, b1, b2;

        tick(); tick();
        check("rst_play", play, 0);
        check("rst_song", song, 0);
        check("rst_reset_play", reset_play, 0);
        check("rst_ready", ready, 0);
        check("rst_beat", beat, 0);
        check("rst_sample", sample, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_beat_cnt", dut.beat_cnt_q, 0);
        reset = 1'b0;
        tick();
        check("rp_after_reset", reset_play, 1);
        tick();
        check("rp_single", reset_play, 0);
        check("idle_play", play, 0);
        check("idle_song", song, 0);

        voice_sample = {16'h0567, 16'h1234};
        frame(r, b, sv, s);
        check("idle_ready", r, 1);
        check("idle_sv", sv, 1);
        check("idle_sample", s, 16'h0000);
        check("ready_one_cycle", ready, 0);
        NewFrame = 1'b1;
        nready = 0;
        repeat (12) begin
            tick();
            if (ready) nready++;
        end
        NewFrame = 1'b0;
        tick(); tick();
        check("held_level_pulses", nready, 1);

        pulse(0, 0, 1, 0, rp);
        check("pp_play", play, 1);
        for (int i = 0; i < 4; i++) begin
            pulse(1, 0, 0, 0, rp);
            check("next_song", song, (i + 1) % 4);
            check("next_play", play, 1);
            check("next_rp", rp, 1);
        end
        pulse(0, 1, 0, 0, rp);
        check("prev_wrap", song, 3);
        pulse(1, 1, 0, 0, rp);
        check("np_song", song, 3);
        check("np_play", play, 1);
        check("np_rp", rp, 0);
        pulse(1, 1, 1, 0, rp);
        check("np_pp_play", play, 0);
        check("np_pp_song", song, 3);
        pulse(0, 0, 1, 0, rp);
        check("replay", play, 1);

        voice_sample = {16'h7000, 16'h7000};
        frame(r, b, sv, s);
        check("sat_pos", s, 16'h7FFF);
        check("sat_pos_sv", sv, 1);
        tick(); tick();
        check("hold_sample", sample, 16'h7FFF);
        check("hold_sv", sample_valid, 0);
        voice_sample = {16'h9000, 16'h9000};
        frame(r, b, sv, s);
        check("sat_neg", s, 16'h8000);
        voice_sample = {16'hFF00, 16'h0100};
        frame(r, b, sv, s);
        check("sum_zero", s, 16'h0000);
        voice_sample = {16'h0200, 16'h0100};
        frame(r, b, sv, s);
        check("sum_plain", s, 16'h0300);

        do_reset();
        nready = 0; nbeats = 0; b1 = 0; b2 = 0;
        for (int i = 1; i <= 130; i++) begin
            frame(r, b, sv, s);
            if (r) nready++;
            if (b) begin
                nbeats++;
                if (nbeats == 1) b1 = i;
                if (nbeats == 2) b2 = i;
            end
        end
        check("beat_readies", nready, 130);
        check("beat_count", nbeats, 2);
        check("beat_first", b1, 64);
        check("beat_second", b2, 128);
        repeat (10) frame(r, b, sv, s);
        pulse(1, 0, 0, 0, rp);
        check("mid_next_rp", rp, 1);
        b1 = 0; nbeats = 0;
        for (int i = 1; i <= 64; i++) begin
            frame(r, b, sv, s);
            if (b) begin
                nbeats++;
                if (b1 == 0) b1 = i;
            end
        end
        check("restart_beat_idx", b1, 64);
        check("restart_beat_count", nbeats, 1);

        do_reset();
        pulse(0, 0, 1, 0, rp);
        pulse(1, 0, 0, 0, rp);
        pulse(1, 0, 0, 0, rp);
        check("sd_pre_song", song, 2);
        pulse(0, 0, 0, 1, rp);
        check("sd_song", song, 3);
        check("sd_rp", rp, 1);
`ifdef MUSIC_PLAYER_AUTOPLAY_EN
        check("sd_play", play, 1);
        pulse(0, 0, 1, 0, rp);
`else
        check("sd_play", play, 0);
`endif
        pulse(0, 0, 0, 1, rp);
        check("sd_paused_song", song, 3);
        check("sd_paused_play", play, 0);
        check("sd_paused_rp", rp, 0);

        do_reset();
        pulse(0, 0, 1, 0, rp);
        pulse(1, 0, 0, 0, rp);
        pulse(1, 0, 0, 0, rp);
        voice_sample = {16'h0200, 16'h0100};
        repeat (40) frame(r, b, sv, s);
        check("mid_cnt", dut.beat_cnt_q, 40);
        check("mid_sample", sample, 16'h0300);
        check("mid_song", song, 2);
        reset = 1'b1;
        tick();
        check("mr_play", play, 0);
        check("mr_song", song, 0);
        check("mr_cnt", dut.beat_cnt_q, 0);
        check("mr_sample", sample, 0);
        reset = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/music_player_poly.md
Name: music_player_poly

Overview:
- Parametrised successor to the single-voice player top.
- Provides the transport state machine, with next, prev, pause and song auto-advance.
- Synchronises the codec frame strobe and generates the beat pulse with a parametrised divider.
- Mixes VOICES external note-player sample streams into one saturated output. Sits between the button one-pulsers, the per-voice song_reader/note_player instances and the codec.

Parameters:
- NUM_SONGS, 4: number of songs; song index wraps modulo NUM_SONGS.
- SONG_BITS, 2: width of song index; must satisfy 2^SONG_BITS >= NUM_SONGS.
- VOICES, 2: number of mixed voices, 1..8.
- SAMPLE_W, 16: signed sample width.
- BEAT_DIV, 1000: frame-ready pulses per beat (64 for simulation builds).
- BEAT_BITS, 10: beat counter width; must satisfy 2^BEAT_BITS >= BEAT_DIV.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play_pause  in  1  one-cycle pulse, toggles play/pause
- next  in  1  one-cycle pulse, advance song
- prev  in  1  one-cycle pulse, previous song
- NewFrame  in  1  codec frame strobe, asynchronous level
- song_done  in  1  end-of-song from song reader(s), one-cycle pulse
- voice_sample  in  VOICES*SAMPLE_W  packed signed samples; voice 0 in LSBs
- ready  out  1  one-cycle synchronised frame pulse, also fans out to the note players
- beat  out  1  one-cycle beat pulse
- play  out  1  high in PLAYING
- song  out  SONG_BITS  current song index
- reset_play  out  1  one-cycle pulse, resets song readers and note players
- sample  out  SAMPLE_W  mixed output sample, signed
- sample_valid  out  1  one-cycle pulse when sample updates

Behaviour:
- Reset values: play=0, song=0, reset_play=0, beat=0, ready=0, sample=0, sample_valid=0, beat counter=0, sync flops=0, state=RESET_PLAY.

Frame sync:
- NewFrame passes through a 2-flop synchroniser, then rising-edge detect.
- ready pulses for 1 cycle, 3 clk after the NewFrame rising edge.
- A level held high produces exactly one pulse.

Beat counter:
- Increments on ready.
- When ready and count==BEAT_DIV-1: beat=1 for that cycle (registered, visible next cycle) and count goes to 0.
- Count is cleared by reset and by reset_play; it is not gated by play.

FSM states: RESET_PLAY, PAUSED, PLAYING, ADVANCE.
- RESET_PLAY: reset_play=1 for exactly one cycle, then go to the resume target. The target is PAUSED after reset.
- PAUSED:
  - play_pause -> PLAYING.
  - next or prev -> ADVANCE, with resume target = PAUSED.
- PLAYING:
  - play_pause -> PAUSED.
  - next or prev -> ADVANCE, with resume target = PLAYING.
  - song_done -> ADVANCE in forward direction, with resume target = PAUSED (see Optional Feature).
- ADVANCE (1 cycle):
  - next: song = (song==NUM_SONGS-1) ? 0 : song+1.
  - prev: song = (song==0) ? NUM_SONGS-1 : song-1.
  - Then go to RESET_PLAY.
- Input priority within one cycle: reset > next/prev > song_done > play_pause.
- next and prev asserted together: both ignored, no state change; a simultaneous play_pause is still honoured.
- Button pulses arriving in ADVANCE or RESET_PLAY are dropped.
- song_done in PAUSED is ignored.
- play=1 only in PLAYING.

Mixer:
- On ready, sum all voices sign-extended to SAMPLE_W+3 bits, then saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- Result is registered into sample on the cycle after ready; sample_valid pulses at that same time.
- If play=0 when ready arrives: sample=0 and sample_valid still pulses.
- sample holds its value between updates.
- reset_play does not clear sample.

Optional Feature:
- MUSIC_PLAYER_AUTOPLAY_EN defined: song_done in PLAYING advances with resume target = PLAYING, so playback continues into the next song.
- Not defined: resume target = PAUSED, so the user must press play_pause to continue.
- No other behaviour differs.

Test Plan:
- Reset then idle:
  - reset_play pulses once 1 cycle after reset deasserts.
  - play=0, song=0.
  - sample=0 on each ready pulse, sample_valid pulses.
- Song index wrap (NUM_SONGS=4):
  - play_pause, then next x4 -> song 1,2,3,0, play=1 after each, one reset_play per advance.
  - From song 0, prev -> song=3.
  - next+prev in the same cycle -> no change.
- Beat division (BEAT_DIV=64):
  - 130 NewFrame rising edges -> ready x130, beat exactly twice: on the 64th and 128th ready.
  - A next press mid-count -> beat counter restarts from 0.
- Mixer saturation (VOICES=2, SAMPLE_W=16, playing):
  - 0x7000+0x7000 -> 0x7FFF.
  - 0x9000+0x9000 -> 0x8000.
  - 0x0100+0xFF00 -> 0x0000.
  - Each result appears 1 cycle after ready.
- song_done while playing song 2:
  - Without the macro: song=3, play=0.
  - With MUSIC_PLAYER_AUTOPLAY_EN: song=3, play=1.
  - song_done while paused -> ignored.
- Reset mid-operation:
  - Assert reset while PLAYING song 2 with beat count at 40 -> next cycle play=0, song=0, beat count=0, sample=0.
